peri_write_sink: RTL and testbench
==================================

Name: peri_write_sink

Overview:
Peripheral-side receiver for the core's memory-mapped peripheral write port. The decode stage drives this port for stores whose address has a nonzero upper byte.
- Captures each write strobe into a small FIFO.
- Drains entries one at a time to a peripheral device (vector engine register bank) over a valid/ready handshake.
- Decodes one control address that issues a "start" pulse after all preceding writes have drained, or clears the sticky overflow flag.
- Raises peri_full so the pipeline can stall.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 16, peripheral address width.
DW, 16, peripheral data width.
CTRL_ADDR, 16'hFFFF, control-register address; writes to it are never queued.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
peri_web  in  1  write strobe, active low; one write per low cycle.
peri_addr  in  AW  write address, valid while peri_web=0.
peri_datao  in  DW  write data, valid while peri_web=0.
peri_full  out  1  FIFO holds DEPTH entries.
dev_valid  out  1  head entry presented to the device.
dev_ready  in  1  device accepts the head entry when high together with dev_valid.
dev_addr  out  AW  address of the head entry.
dev_data  out  DW  data of the head entry.
dev_start  out  1  one-cycle start pulse.
fifo_count  out  $clog2(DEPTH)+1  number of entries held.
overflow  out  1  sticky flag: a write was dropped.
busy  out  1  FIFO non-empty, or FSM not IDLE, or kick_pending set.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - FSM to IDLE; read/write pointers and count to 0; kick_pending=0; overflow=0.
  - All outputs to 0; dev_addr and dev_data to 0.
  - Reset mid-operation discards all queued entries and any pending kick. No dev_start is generated on reset release.
- Capture, evaluated at each rising edge where peri_web=0:
  - If peri_addr==CTRL_ADDR:
    - data[0]=1 sets kick_pending.
    - data[1]=1 clears overflow. The clear is skipped if a drop occurs at the same edge (set wins).
    - Other data bits are ignored; nothing is queued.
  - Else, if count<DEPTH (registered value before the edge), push {peri_addr, peri_datao}.
  - Else, drop the write and set overflow. A pop at the same edge does not make room.
- peri_full = (count==DEPTH). It is registered-derived with no combinational path from inputs.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - A push and a pop at the same edge leave count unchanged.
  - dev_addr/dev_data always show the entry at the read pointer and must not change while dev_valid=1 and dev_ready=0.
- Drain FSM states: IDLE, SEND, KICK.
  - IDLE: if count>0, go to SEND. Else, if kick_pending, go to KICK. Else stay.
  - SEND: dev_valid=1.
    - When dev_ready=1: pop.
    - After the pop, if count after the pop >0, stay in SEND (back-to-back, one transfer per cycle).
    - Else, if kick_pending (registered), go to KICK.
    - Else go to IDLE.
    - When dev_ready=0: hold.
  - KICK: dev_start=1 for exactly one cycle; clear kick_pending; go to IDLE. A kick captured at the same edge re-sets kick_pending, and set wins.
  - Ordering: dev_start is never asserted while any entry written before the kick is still queued. Entries written after the kick may still be queued.
- Latency: for a write captured at edge N into an empty, idle block, dev_valid is high from edge N+1.
- A kick into an idle, empty block: kick_pending=1 from edge N, FSM enters KICK at edge N+1, and dev_start is high during the cycle following edge N+1.
- dev_ready while dev_valid=0 is ignored.

Test Plan:
1. Single write: peri_web=0, addr=16'h0120, data=16'hABCD for one cycle, dev_ready=1. Expect dev_valid high exactly 1 cycle starting 1 edge after capture, dev_addr=16'h0120, dev_data=16'hABCD, fifo_count back to 0, and busy falls.
2. Fill and overflow: dev_ready=0; write 5 entries (0x0100..0x0104). Expect:
   - peri_full=1 after the 4th write; 5th write dropped; overflow=1.
   - After dev_ready=1, exactly 4 transfers 0x0100..0x0103 on consecutive cycles, no 0x0104.
3. Kick ordering: dev_ready=0; write 0x0200, 0x0201, then CTRL_ADDR data=1. After 3 cycles set dev_ready=1. Expect both transfers in order, then dev_start one cycle after the last handshake, and dev_start never high before that.
4. Backpressure stability: write 0x0300/0x1111; toggle dev_ready 0,0,1. Expect dev_addr/dev_data constant while stalled and a single pop.
5. Overflow clear: after scenario 2, write CTRL_ADDR data=2. Expect overflow=0 next cycle, no dev_start, fifo_count unchanged. Also repeat the clear together with a dropped write in the same cycle; expect overflow stays 1.
6. Reset mid-operation: with 3 entries queued, kick_pending=1 and dev_valid=1, pulse rst_n low asynchronously mid-cycle. Expect all outputs 0 immediately, and no dev_valid or dev_start after release without new writes.

Source files
------------

// File: rtl/peri_write_sink.sv
// peri_write_sink: queues peripheral writes in a small FIFO, drains them to a device over valid/ready,
// and issues an ordered start pulse once every write queued before the kick has drained.
module peri_write_sink #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter logic [AW-1:0] CTRL_ADDR = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       peri_web,
  input  logic [AW-1:0]              peri_addr,
  input  logic [DW-1:0]              peri_datao,
  output logic                       peri_full,
  output logic                       dev_valid,
  input  logic                       dev_ready,
  output logic [AW-1:0]              dev_addr,
  output logic [DW-1:0]              dev_data,
  output logic                       dev_start,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, SEND, KICK} state_t;
  state_t state_q;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic kick_q, kick_d, ovf_q, ovf_d;
  logic is_ctrl, full, push, pop, drop;
  assign is_ctrl = !peri_web && peri_addr == CTRL_ADDR;
  assign full = count_q == CW'(DEPTH);
  assign push = !peri_web && !is_ctrl && !full;
  assign drop = !peri_web && !is_ctrl && full;
  assign pop = state_q == SEND && dev_ready;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // a kick captured while in KICK re-arms rather than being lost
  assign kick_d = (is_ctrl && peri_datao[0]) || (kick_q && state_q != KICK);
  assign ovf_d = drop || (ovf_q && !(is_ctrl && peri_datao[1]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      kick_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_q == IDLE ? (count_q != '0 ? SEND : kick_q ? KICK : IDLE)
               : state_q == SEND ? (!dev_ready || count_d != '0 ? SEND : kick_q ? KICK : IDLE)
               : IDLE;
      if (push) begin
        addr_q[wr_q] <= peri_addr;
        data_q[wr_q] <= peri_datao;
        wr_q <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      count_q <= count_d;
      kick_q <= kick_d;
      ovf_q <= ovf_d;
    end
  end
  assign peri_full = full;
  assign dev_valid = state_q == SEND;
  assign dev_start = state_q == KICK;
  assign dev_addr = addr_q[rd_q];
  assign dev_data = data_q[rd_q];
  assign fifo_count = count_q;
  assign overflow = ovf_q;
  assign busy = count_q != '0 || state_q != IDLE || kick_q;
endmodule

// File: tb/tb_peri_write_sink.sv
// tb_peri_write_sink: scenario tasks plus a scoreboard monitor that checks every device handshake in order.
module tb_peri_write_sink;
  localparam logic [15:0] CTRL = 16'hFFFF;
  logic clk = 1'b0, rst_n = 1'b0, peri_web = 1'b1, dev_ready = 1'b0;
  logic [15:0] peri_addr = '0, peri_datao = '0;
  logic peri_full, dev_valid, dev_start, overflow, busy;
  logic [15:0] dev_addr, dev_data;
  logic [2:0] fifo_count;
  int checks = 0, fails = 0, xfers = 0;
  logic [31:0] sb [$];

  peri_write_sink dut (
    .clk(clk), .rst_n(rst_n), .peri_web(peri_web), .peri_addr(peri_addr),
    .peri_datao(peri_datao), .peri_full(peri_full), .dev_valid(dev_valid),
    .dev_ready(dev_ready), .dev_addr(dev_addr), .dev_data(dev_data),
    .dev_start(dev_start), .fifo_count(fifo_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // monitor samples just before each rising edge, once inputs are settled
  always @(negedge clk) begin
    logic [31:0] exp;
    #4;
    if (rst_n && dev_valid && dev_ready) begin
      checks++;
      xfers++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL xfer: unexpected transfer addr=%h data=%h, required none", dev_addr, dev_data);
      end else begin
        exp = sb.pop_front();
        if ({dev_addr, dev_data} !== exp) begin
          fails++;
          $display("FAIL xfer: got addr=%h data=%h, required addr=%h data=%h", dev_addr, dev_data, exp[31:16], exp[15:0]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    peri_web = 1'b0;
    peri_addr = a;
    peri_datao = d;
    step();
    peri_web = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({peri_full, dev_valid, dev_start, overflow, busy, fifo_count, dev_addr, dev_data} !== 40'h0) begin
      fails++;
      $display("FAIL reset: outputs=%h required 0", {peri_full, dev_valid, dev_start, overflow, busy, fifo_count, dev_addr, dev_data});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int x0 = xfers;
    dev_ready = 1'b1;
    sb.push_back({16'h0120, 16'hABCD});
    wr(16'h0120, 16'hABCD);
    checks++;
    if (fifo_count !== 3'd1 || dev_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_capture: count=%0d valid=%b required 1 0", fifo_count, dev_valid);
    end
    step();
    checks++;
    if (dev_valid !== 1'b1 || dev_addr !== 16'h0120 || dev_data !== 16'hABCD) begin
      fails++;
      $display("FAIL single_present: valid=%b addr=%h data=%h required 1 0120 abcd", dev_valid, dev_addr, dev_data);
    end
    step();
    checks++;
    if (dev_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || xfers - x0 != 1) begin
      fails++;
      $display("FAIL single_done: valid=%b count=%0d busy=%b xfers=%0d required 0 0 0 1", dev_valid, fifo_count, busy, xfers - x0);
    end
  endtask

  task automatic test_fill_overflow();
    int x0;
    dev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back({16'h0100 + 16'(i), 16'hA000 + 16'(i)});
      wr(16'h0100 + 16'(i), 16'hA000 + 16'(i));
      if (i == 3) begin
        checks++;
        if (peri_full !== 1'b1 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL fill_full: full=%b overflow=%b required 1 0", peri_full, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4 || dev_valid !== 1'b1) begin
      fails++;
      $display("FAIL fill_drop: overflow=%b count=%0d valid=%b required 1 4 1", overflow, fifo_count, dev_valid);
    end
    x0 = xfers;
    dev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fifo_count !== 3'(3 - i)) begin
        fails++;
        $display("FAIL fill_drain: count=%0d required %0d", fifo_count, 3 - i);
      end
    end
    checks++;
    if (xfers - x0 != 4 || sb.size() != 0 || dev_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_total: xfers=%0d left=%0d valid=%b required 4 0 0", xfers - x0, sb.size(), dev_valid);
    end
  endtask

  task automatic test_overflow_clear();
    wr(CTRL, 16'h0002);
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 3'd0 || dev_start !== 1'b0) begin
      fails++;
      $display("FAIL clr: overflow=%b count=%0d start=%b required 0 0 0", overflow, fifo_count, dev_start);
    end
    step();
    checks++;
    if (dev_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clr_nokick: start=%b busy=%b required 0 0", dev_start, busy);
    end
    dev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({16'h0110 + 16'(i), 16'h5500 + 16'(i)});
      wr(16'h0110 + 16'(i), 16'h5500 + 16'(i));
    end
    wr(16'h0114, 16'h0000);
    wr(CTRL, 16'h0002);
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL clr_full: overflow=%b count=%0d required 0 4", overflow, fifo_count);
    end
    wr(16'h0115, 16'h0000);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL clr_then_drop: overflow=%b count=%0d required 1 4", overflow, fifo_count);
    end
    dev_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) step();
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL clr_drain: busy=%b left=%0d required 0 0", busy, sb.size());
    end
  endtask

  task automatic test_kick_order();
    int starts = 0, lh = -1, sc = -1;
    dev_ready = 1'b0;
    sb.push_back({16'h0200, 16'h0A00});
    wr(16'h0200, 16'h0A00);
    sb.push_back({16'h0201, 16'h0A01});
    wr(16'h0201, 16'h0A01);
    wr(CTRL, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      if (dev_start) starts++;
      step();
    end
    checks++;
    if (starts != 0) begin
      fails++;
      $display("FAIL kick_early: starts=%0d required 0", starts);
    end
    dev_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (dev_start) begin
        starts++;
        sc = c;
        checks++;
        if (sb.size() != 0) begin
          fails++;
          $display("FAIL kick_pending_data: entries left=%0d at start, required 0", sb.size());
        end
      end
      if (dev_valid && dev_ready) lh = c;
    end
    checks++;
    if (starts != 1 || sc != lh + 1) begin
      fails++;
      $display("FAIL kick_timing: starts=%0d start_cycle=%0d last_hs=%0d required 1 and start=last_hs+1", starts, sc, lh);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL kick_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back_stall();
    int x0 = xfers;
    dev_ready = 1'b0;
    sb.push_back({16'h0300, 16'h1111});
    wr(16'h0300, 16'h1111);
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dev_valid !== 1'b1 || dev_addr !== 16'h0300 || dev_data !== 16'h1111) begin
        fails++;
        $display("FAIL stall_hold: valid=%b addr=%h data=%h required 1 0300 1111", dev_valid, dev_addr, dev_data);
      end
      step();
    end
    dev_ready = 1'b1;
    step();
    dev_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0 || xfers - x0 != 1 || dev_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_pop: count=%0d xfers=%0d valid=%b required 0 1 0", fifo_count, xfers - x0, dev_valid);
    end
  endtask

  task automatic test_reset_mid();
    dev_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(16'h0400 + 16'(i), 16'h7700 + 16'(i));
    wr(CTRL, 16'h0001);
    checks++;
    if (fifo_count !== 3'd3 || dev_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_setup: count=%0d valid=%b busy=%b required 3 1 1", fifo_count, dev_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({peri_full, dev_valid, dev_start, overflow, busy, fifo_count, dev_addr, dev_data} !== 40'h0) begin
      fails++;
      $display("FAIL rst_async: outputs=%h required 0", {peri_full, dev_valid, dev_start, overflow, busy, fifo_count, dev_addr, dev_data});
    end
    step();
    #2 rst_n = 1'b1;
    dev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dev_valid !== 1'b0 || dev_start !== 1'b0) begin
        fails++;
        $display("FAIL rst_release: valid=%b start=%b required 0 0", dev_valid, dev_start);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_overflow_clear();
    test_kick_order();
    test_back_to_back_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
